// File: rtl/r2000_multdiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : r2000_multdiv_ctrl_if
// Description : Control/data bus between the mult/div controller and the
//               r2000_multdiv HI/LO unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface r2000_multdiv_ctrl_if #(
    parameter int DW = 32
);
    logic [DW-1:0] md_operand1_o;
    logic [DW-1:0] md_operand2_o;
    logic          md_sign_o;
    logic          md_mult_div_o;
    logic          md_start_o;
    logic          md_hiw_o;
    logic          md_low_o;
    logic [DW-1:0] md_datain_o;
    logic [DW-1:0] md_hi_i;
    logic [DW-1:0] md_lo_i;
    logic          md_ready_i;

    modport master (
        output md_operand1_o, md_operand2_o, md_sign_o, md_mult_div_o,
               md_start_o, md_hiw_o, md_low_o, md_datain_o,
        input  md_hi_i, md_lo_i, md_ready_i
    );

    modport slave (
        input  md_operand1_o, md_operand2_o, md_sign_o, md_mult_div_o,
               md_start_o, md_hiw_o, md_low_o, md_datain_o,
        output md_hi_i, md_lo_i, md_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/r2000_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : r2000_multdiv_ctrl
// Description : Sequences MULT/DIV/MTxx/MFxx requests onto the HI/LO unit and
//               stalls the pipeline while a request cannot be served.
//               Optional macro MULTDIV_DIVZERO_EN: divide by zero is trapped.
// Revision    : 1.0 - initial release
// ============================================================================
module r2000_multdiv_ctrl #(
    parameter int DW = 32
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    input  wire logic          op_valid_i,
    input  wire logic [2:0]    op_i,
    input  wire logic [DW-1:0] rs_i,
    input  wire logic [DW-1:0] rt_i,
    output logic               stall_o,
    output logic [DW-1:0]      rd_data_o,
    output logic               rd_valid_o,
    output logic               busy_o,
    output logic               divz_o,
    r2000_multdiv_ctrl_if.master md
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_MOVE  = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_armed;
    logic          r_move_hi;
    logic          r_sign;
    logic          r_mult_div;
    logic          r_rd_valid;
    logic [DW-1:0] r_op1;
    logic [DW-1:0] r_op2;
    logic [DW-1:0] r_datain;
    logic [DW-1:0] r_rd_data;

    logic w_idle;
    logic w_accept;
    logic w_is_md;
    logic w_is_mt;
    logic w_is_mf;
    logic w_divz_req;
    logic w_issue;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = op_valid_i & w_idle;
    assign w_is_md  = ~op_i[2];
    assign w_is_mt  = op_i[2] & ~op_i[1];
    assign w_is_mf  = op_i[2] & op_i[1];
    assign w_issue  = w_accept & w_is_md & ~w_divz_req;

`ifdef MULTDIV_DIVZERO_EN
    logic r_divz;

    assign w_divz_req = ~op_i[2] & op_i[1] & (rt_i == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_divz <= 1'b0;
        end else begin
            r_divz <= w_accept & w_divz_req;
        end
    end

    assign divz_o = r_divz;
`else
    assign w_divz_req = 1'b0;
    assign divz_o     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_ISSUE;
                end else if (w_accept & w_is_mt) begin
                    w_state_nxt = S_MOVE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            // Only a ready that rose after being seen low marks completion.
            S_WAIT:  if (r_armed & md.md_ready_i) w_state_nxt = S_IDLE;
            S_MOVE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_armed    <= 1'b0;
            r_move_hi  <= 1'b0;
            r_sign     <= 1'b0;
            r_mult_div <= 1'b0;
            r_rd_valid <= 1'b0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_datain   <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_accept & w_is_mf;
            if (w_accept & w_is_mf) begin
                r_rd_data <= op_i[0] ? md.md_lo_i : md.md_hi_i;
            end
            if (w_issue) begin
                r_op1      <= rs_i;
                r_op2      <= rt_i;
                r_sign     <= ~op_i[0];
                r_mult_div <= ~op_i[1];
            end
            if (w_accept & w_is_mt) begin
                r_datain  <= rs_i;
                r_move_hi <= ~op_i[0];
            end
            if (r_state == S_ISSUE) begin
                r_armed <= 1'b0;
            end else if ((r_state == S_WAIT) && !md.md_ready_i) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign stall_o           = op_valid_i & ~w_idle;
    assign busy_o            = ~w_idle;
    assign rd_data_o         = r_rd_data;
    assign rd_valid_o        = r_rd_valid;
    assign md.md_operand1_o  = r_op1;
    assign md.md_operand2_o  = r_op2;
    assign md.md_sign_o      = r_sign;
    assign md.md_mult_div_o  = r_mult_div;
    assign md.md_start_o     = (r_state == S_ISSUE);
    assign md.md_hiw_o       = (r_state == S_MOVE) & r_move_hi;
    assign md.md_low_o       = (r_state == S_MOVE) & ~r_move_hi;
    assign md.md_datain_o    = r_datain;

endmodule
`default_nettype wire

// File: doc/r2000_multdiv_ctrl.md
# r2000_multdiv_ctrl

Sequencing controller between the R2000 execute stage and the `r2000_multdiv` HI/LO unit. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests and latches operands. It drives the unit's start, operation, sign and write-port controls, tracks completion through the unit's ready signal, and stalls the pipeline whenever a request cannot be served.

## Interface
Parameters:
- `DW`, 32, datapath width; must match the unit's `` `dw ``.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `op_valid_i`  in  1  request present this cycle.
- `op_i`  in  3  request code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
  - 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
- `rs_i`  in  DW  first operand / MTHI, MTLO data.
- `rt_i`  in  DW  second operand.
- `stall_o`  out  1  request not accepted; the core holds `op_valid_i`, `op_i`, `rs_i`, `rt_i`.
- `rd_data_o`  out  DW  MFHI/MFLO result.
- `rd_valid_o`  out  1  `rd_data_o` valid; one-cycle pulse.
- `busy_o`  out  1  state is not IDLE.
- `divz_o`  out  1  divide-by-zero pulse (see Configuration).
- `md_operand1_o`, `md_operand2_o`  out  DW  latched operands to the unit.
- `md_sign_o`  out  1  1 for MULT/DIV.
- `md_mult_div_o`  out  1  1 = multiply, 0 = divide.
- `md_start_o`  out  1  one-cycle start pulse.
- `md_hiw_o`, `md_low_o`  out  1  HI/LO write strobes.
- `md_datain_o`  out  DW  write data.
- `md_hi_i`, `md_lo_i`  in  DW  unit HI/LO.
- `md_ready_i`  in  1  unit ready.

## Operation
- States: IDLE, ISSUE, WAIT, MOVE.
- Accept = `op_valid_i & ~stall_o`. Requests are accepted only in IDLE.
- `stall_o` = `op_valid_i & (state != IDLE)`. This is combinational, and it covers every opcode, including MF* while a multiply or divide is in flight.
- Accept of MULT/MULTU/DIV/DIVU:
  - Register `rs_i`, `rt_i`, sign and operation onto the `md_*` outputs.
  - Transition IDLE→ISSUE.
- ISSUE: `md_start_o`=1 for exactly one cycle, then →WAIT. Clear the `armed` flag.
- WAIT:
  - `armed` is set on any cycle with `md_ready_i`=0.
  - Completion is `armed & md_ready_i`, which then transitions →IDLE. A stale ready level held from the previous operation is therefore ignored.
- MTHI/MTLO accept:
  - IDLE→MOVE.
  - In MOVE, `md_datain_o`=latched `rs_i` and `md_hiw_o` or `md_low_o`=1 for one cycle, then →IDLE.
- MFHI/MFLO accept:
  - No state change.
  - Next cycle, `rd_valid_o`=1 and `rd_data_o`=`md_hi_i`/`md_lo_i` as sampled at the accept edge.
- Operand registers hold their value until the next MULT/DIV accept. `md_operand*_o` is stable throughout WAIT.
- Reset (any time, including in WAIT):
  - State→IDLE.
  - All outputs 0: `md_*`, `rd_data_o`, `rd_valid_o`, `busy_o`, `divz_o`, `stall_o`.
  - `armed` is cleared.
  - HI/LO contents are the unit's responsibility.

## Timing
- Multiply/divide accepted at edge T:
  - `md_start_o` is high during cycle T+1.
  - WAIT begins at T+2.
  - If completion is sampled at edge R, the state is IDLE after R. `stall_o` and `busy_o` drop in the cycle following R.
  - Controller overhead is 2 cycles beyond the unit latency.
- MTHI/MTLO accepted at T: strobe high in cycle T+1, IDLE from T+2. A request in cycle T+1 stalls for one cycle.
- MFHI/MFLO accepted at T: `rd_valid_o` is high in cycle T+1. MF* requests are accepted back-to-back, one per cycle.
- `md_ready_i` low → high within ISSUE is not counted; arming starts in WAIT.

## Configuration
- `MULTDIV_DIVZERO_EN` defined:
  - A DIV/DIVU accepted with `rt_i`==0 is not issued and the state stays IDLE.
  - `divz_o`=1 in cycle T+1.
  - HI/LO are unchanged.
- Undefined:
  - The divide is issued normally, and the result is whatever the unit produces.
  - `divz_o` is tied 0.

## Test plan
- MULTU 56×89, then MFLO/MFHI:
  - Stall is held until completion.
  - `rd_data_o`=0x00001378, then 0x00000000.
  - `md_start_o` is a single one-cycle pulse.
- MULT 0xFFFFFFFB×0x12345678: LO=0xA4FA4FA8, HI=0xFFFFFFFF.
- DIVU 0x456/0x23: LO=0x0000001F, HI=0x00000019.
- MFLO issued in the cycle after a MULT accept:
  - `stall_o`=1 until the cycle after completion.
  - The result comes from the new product, never the old LO.
- MTHI rs=0xDEADBEEF, then MFHI next cycle:
  - `md_hiw_o` pulse with `md_datain_o`=0xDEADBEEF.
  - `rd_data_o`=0xDEADBEEF.
- Reset asserted mid-WAIT:
  - All outputs go to 0 immediately (asynchronous).
  - After release, a new MULTU 3×4 completes with LO=0x0000000C.
  - With `MULTDIV_DIVZERO_EN`, DIV by 0 gives `divz_o` pulse, no `md_start_o`, no stall.
